// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU datapath: normaliser states, IEEE 754 field
// sizes and the bit positions of the result flags.
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int EXP_BIAS = 127;
   localparam int EXP_INF  = 255;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 25;
   localparam int EXP_W    = 10;

   localparam int FLAG_OVF  = 2;
   localparam int FLAG_UNF  = 1;
   localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/fpu_normalize.sv
// Iterative normaliser: one mantissa shift per cycle until the hidden bit is
// set, then range-check the exponent and pack an IEEE 754 single-precision word.
module fpu_normalize #(
   parameter int MANT_W = 25,
   parameter int EXP_W  = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic signed [EXP_W-1:0] in_exponent,
   input  logic [MANT_W-1:0]       in_mantissa,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             outp,
   output logic [2:0]              out_flags
);
   import fpu_pkg::state_t;
   import fpu_pkg::IDLE;
   import fpu_pkg::NORM;
   import fpu_pkg::DONE;
   import fpu_pkg::EXP_INF;
   import fpu_pkg::FRAC_W;
   import fpu_pkg::FLAG_OVF;
   import fpu_pkg::FLAG_UNF;
   import fpu_pkg::FLAG_ZERO;

   localparam logic signed [EXP_W-1:0] C_EXP_INF  = EXP_W'(EXP_INF);
   localparam logic signed [EXP_W-1:0] C_EXP_ZERO = '0;
   localparam logic signed [EXP_W-1:0] C_EXP_ONE  = EXP_W'(1);

   state_t                    r_state;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic [31:0]               r_outp;
   logic [2:0]                r_flags;
   logic                      r_sign;
   logic signed [EXP_W-1:0]   r_exp;
   logic [MANT_W-1:0]         r_mant;

   logic                      w_mant_zero;
   logic                      w_carry;
   logic                      w_hidden;
   logic                      w_pack;
   logic [31:0]               w_pack_word;
   logic [2:0]                w_pack_flags;

   assign w_mant_zero = (r_mant == '0);
   assign w_carry     = r_mant[MANT_W-1];
   assign w_hidden    = r_mant[FRAC_W];
   // Pack when there is nothing left to shift: zero, or hidden bit alone on top.
   assign w_pack      = w_mant_zero || (!w_carry && w_hidden);

   always_comb begin
      w_pack_word  = {r_sign, 31'h0};
      w_pack_flags = '0;
      if (w_mant_zero) begin
         w_pack_flags[FLAG_ZERO] = 1'b1;
      end else if (r_exp >= C_EXP_INF) begin
         w_pack_word            = {r_sign, 8'hFF, 23'h0};
         w_pack_flags[FLAG_OVF] = 1'b1;
      end else if (r_exp <= C_EXP_ZERO) begin
         // Denormals are not produced; tiny results flush to signed zero.
         w_pack_flags[FLAG_UNF] = 1'b1;
      end else begin
         w_pack_word = {r_sign, r_exp[7:0], r_mant[FRAC_W-1:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_outp      <= '0;
         r_flags     <= '0;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mant      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sign     <= in_sign;
                  r_exp      <= in_exponent;
                  r_mant     <= in_mantissa;
                  r_in_ready <= 1'b0;
                  r_state    <= NORM;
               end
            end
            NORM: begin
               if (w_pack) begin
                  r_outp      <= w_pack_word;
                  r_flags     <= w_pack_flags;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (w_carry) begin
                  // Truncating right shift: the dropped lsb is discarded.
                  r_mant <= r_mant >> 1;
                  r_exp  <= r_exp + C_EXP_ONE;
               end else begin
                  r_mant <= r_mant << 1;
                  r_exp  <= r_exp - C_EXP_ONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign outp      = r_outp;
   assign out_flags = r_flags;

endmodule

// File: tb/tb_fpu_normalize.sv
// Bench for fpu_normalize: directed vector table, reset/backpressure sequences
// and random operands checked against a leading-one based arithmetic model.
module tb_fpu_normalize;
   import fpu_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic signed [9:0] in_exponent;
   logic [24:0]       in_mantissa;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       outp;
   logic [2:0]        out_flags;

   int total = 0;
   int bad   = 0;

   fpu_normalize #(.MANT_W(25), .EXP_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exponent(in_exponent),
      .in_mantissa(in_mantissa),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .outp       (outp),
      .out_flags  (out_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      int          e;
      logic [24:0] m;
      int          bp;
      logic [31:0] w;
      logic [2:0]  f;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Value-level model: locate the leading one, rescale, truncate, range-check.
   function automatic void model(input logic s, input int e, input logic [24:0] m,
                                 output logic [31:0] w, output logic [2:0] f, output int lat);
      int          p;
      int          en;
      logic [24:0] mn;
      if (m == 25'd0) begin
         w = {s, 31'h0};
         f = 3'b001;
         lat = 2;
         return;
      end
      p = 24;
      while (!m[p]) p--;
      en  = e + p - 23;
      mn  = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
      lat = (p == 24) ? 3 : 2 + (23 - p);
      if (en >= 255) begin
         w = {s, 8'hFF, 23'h0};
         f = 3'b100;
      end else if (en <= 0) begin
         w = {s, 31'h0};
         f = 3'b010;
      end else begin
         w = {s, en[7:0], mn[22:0]};
         f = 3'b000;
      end
   endfunction

   task automatic scramble_inputs(input logic v);
      in_valid    = v;
      in_sign     = 1'($urandom);
      in_exponent = 10'($urandom);
      in_mantissa = 25'($urandom);
   endtask

   task automatic run_op(input string tag, input logic s, input int e, input logic [24:0] m,
                         input int bp, input logic [31:0] xw, input logic [2:0] xf, input int xlat);
      int          lat;
      logic        busy_err;
      logic        hold_err;
      logic [31:0] w;
      logic [2:0]  f;
      lat = 0;
      busy_err = 1'b0;
      hold_err = 1'b0;
      @(negedge clk);
      in_valid    = 1'b1;
      in_sign     = s;
      in_exponent = 10'(e);
      in_mantissa = m;
      chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
         if (in_ready) busy_err = 1'b1;
         scramble_inputs(1'($urandom));
      end
      if (lat == 0) begin
         chk({tag, " timeout"}, 32'(out_valid), 32'd1);
         in_valid = 1'b0;
         return;
      end
      w = outp;
      f = out_flags;
      chk({tag, " latency"}, 32'(lat), 32'(xlat));
      chk({tag, " outp"}, w, xw);
      chk({tag, " flags"}, 32'(f), 32'(xf));
      chk({tag, " busy_ready"}, 32'(busy_err), 32'd0);
      for (int k = 0; k < bp; k++) begin
         scramble_inputs(1'b1);
         @(negedge clk);
         if (outp !== w || out_flags !== f || out_valid !== 1'b1 || in_ready !== 1'b0)
            hold_err = 1'b1;
      end
      if (bp > 0) chk({tag, " backpressure_hold"}, 32'(hold_err), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, " valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, " ready_back"}, 32'(in_ready), 32'd1);
      $display("op %s s=%0d e=%0d m=%h bp=%0d -> outp=%h flags=%b lat=%0d", tag, s, e, m, bp, w, f, lat);
   endtask

   initial begin
      logic [31:0] mw;
      logic [2:0]  mf;
      int          ml;
      int          pos;
      int          re;
      logic [24:0] rm;

      vecs[0] = '{s:1'b0, e:127,  m:25'h0800000, bp:0, w:32'h3F800000, f:3'b000, lat:2};
      vecs[1] = '{s:1'b0, e:127,  m:25'h1000000, bp:1, w:32'h40000000, f:3'b000, lat:3};
      vecs[2] = '{s:1'b1, e:127,  m:25'h1000001, bp:0, w:32'hC0000000, f:3'b000, lat:3};
      vecs[3] = '{s:1'b0, e:127,  m:25'h0000001, bp:0, w:32'h34000000, f:3'b000, lat:25};
      vecs[4] = '{s:1'b1, e:50,   m:25'h0000000, bp:0, w:32'h80000000, f:3'b001, lat:2};
      vecs[5] = '{s:1'b0, e:254,  m:25'h1000000, bp:5, w:32'h7F800000, f:3'b100, lat:3};
      vecs[6] = '{s:1'b0, e:1,    m:25'h0400000, bp:0, w:32'h00000000, f:3'b010, lat:3};
      vecs[7] = '{s:1'b0, e:254,  m:25'h0FFFFFF, bp:2, w:32'h7F7FFFFF, f:3'b000, lat:2};
      vecs[8] = '{s:1'b1, e:-256, m:25'h0800000, bp:0, w:32'h80000000, f:3'b010, lat:2};
      vecs[9] = '{s:1'b1, e:255,  m:25'h0C00000, bp:0, w:32'hFF800000, f:3'b100, lat:2};

      rst = 1'b1;
      in_valid = 1'b0;
      in_sign = 1'b0;
      in_exponent = '0;
      in_mantissa = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset outp", outp, 32'd0);
      chk("reset flags", 32'(out_flags), 32'd0);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].bp,
                vecs[i].w, vecs[i].f, vecs[i].lat);

      // Reset pulse sampled at T+5 of a 23-shift operation.
      @(negedge clk);
      in_valid = 1'b1;
      in_sign = 1'b0;
      in_exponent = 10'sd127;
      in_mantissa = 25'h0000001;
      @(posedge clk);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midop_rst out_valid", 32'(out_valid), 32'd0);
      chk("midop_rst in_ready", 32'(in_ready), 32'd1);
      chk("midop_rst outp", outp, 32'd0);
      chk("midop_rst flags", 32'(out_flags), 32'd0);
      $display("op midop_rst applied at T+5");
      run_op("after_rst", 1'b0, 127, 25'h0800000, 0, 32'h3F800000, 3'b000, 2);

      for (int i = 0; i < 40; i++) begin
         pos = $urandom_range(25);
         re  = int'($urandom_range(511)) - 256;
         if (pos == 25) begin
            rm = '0;
         end else begin
            rm = 25'($urandom) & ((25'd1 << pos) - 25'd1);
            rm[pos] = 1'b1;
         end
         model(1'($urandom), re, rm, mw, mf, ml);
         run_op($sformatf("rnd%0d", i), mw[31], re, rm, $urandom_range(3), mw, mf, ml);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_normalize.md
# fpu_normalize

Downstream stage of the single-precision FPU datapath. It accepts a raw, un-normalised arithmetic result (sign, wide biased exponent, 25-bit mantissa with carry and hidden bit) and normalises it iteratively, one shift per cycle. It checks exponent overflow and underflow, then packs an IEEE 754 single-precision word. Upstream and downstream connect through valid/ready handshakes, so a multi-cycle normalisation stalls the producer instead of dropping results.

## Interface
Parameters:
- MANT_W, 25, raw mantissa width: bit 24 = carry, bit 23 = hidden, bits 22:0 = fraction.
- EXP_W, 10, signed internal exponent width (biased, bias 127), wide enough to express underflow/overflow without wrap.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  raw result present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign.
- in_exponent  in  EXP_W  signed biased exponent.
- in_mantissa  in  MANT_W  raw mantissa.
- out_valid  out  1  packed result present.
- out_ready  in  1  consumer accepts.
- outp  out  32  IEEE 754 word {sign, exp[7:0], frac[22:0]}.
- out_flags  out  3  {overflow, underflow, zero}.

## Operation
- States: IDLE, NORM, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, latch sign, exponent and mantissa, then go to NORM.
- NORM evaluates once per cycle, in this priority order:
  - mantissa==0: pack signed zero {sign, 0, 0}, set flag zero, go to DONE.
  - m[24]=1: m>>=1, exp+=1, stay in NORM.
  - m[23]=0: m<<=1, exp-=1, stay in NORM.
  - otherwise, pack:
    - exp>=255: outp={sign,8'hFF,23'h0}, flag overflow.
    - exp<=0: outp={sign,31'h0}, flag underflow; flush to zero, no denormals.
    - else: outp={sign,exp[7:0],m[22:0]}.
    - Go to DONE.
- Fraction handling: truncation only, no rounding. Bits shifted out on a right shift are discarded.
- DONE: out_valid=1 and outp/out_flags held stable. On out_ready go to IDLE; out_valid drops the next cycle.
- At most 1 right shift or 23 left shifts per operation. Termination is guaranteed because a non-zero mantissa reaches bit 23 within 23 left shifts.
- Exponent arithmetic is signed EXP_W; it never wraps within the shift bounds for any in_exponent in [-256, 255].

## Timing
- Reset (synchronous): state=IDLE, in_ready=1, out_valid=0, outp=0, out_flags=0, internal registers 0.
- rst asserted mid-NORM or in DONE abandons the operation. No out_valid is emitted for it.
- Accept at edge T:
  - Already-normal mantissa: out_valid at T+2.
  - Zero mantissa: out_valid at T+2.
  - Carry set: out_valid at T+3.
  - k left shifts: out_valid at T+2+k; worst case T+25.
- in_ready=0 from the cycle after accept until the cycle after the DONE handshake. No input overlap or pipelining; throughput is one result per (latency+1) cycles.
- in_* are sampled only on the accept edge. Changes while busy are ignored.
- outp and out_flags change only on the NORM→DONE transition or reset.

## Structure
- Shared package fpu_pkg holds:
  - state enum {IDLE, NORM, DONE}
  - constants EXP_BIAS=127, EXP_INF=255, FRAC_W=23, MANT_W=25, EXP_W=10
  - flag bit indices FLAG_OVF=2, FLAG_UNF=1, FLAG_ZERO=0
- Single module, no sub-module. Packing and range checks are small enough to live as combinational logic beside the FSM.

## Test plan
- sign 0, exp 127, mant 0x800000, out_ready=1: outp 0x3F800000, flags 0, out_valid at T+2.
- sign 0, exp 127, mant 0x1000000 (carry): outp 0x40000000 at T+3. sign 1, exp 127, mant 0x1000001: outp 0xC0000000, lsb truncated.
- exp 127, mant 0x000001: 23 left shifts, outp 0x34000000 at T+25. in_ready stays 0 throughout; in_valid toggling while busy is ignored.
- Zero, overflow and underflow (one case each):
  - sign 1, mant 0: outp 0x80000000, flags 3'b001.
  - exp 254, mant 0x1000000: outp 0x7F800000, flags 3'b100.
  - exp 1, mant 0x400000: outp 0x00000000, flags 3'b010.
- Backpressure: out_ready low for 5 cycles in DONE. outp/out_valid hold stable; a second in_valid is not accepted until the cycle after the handshake; back-to-back results arrive in order.
- Reset: rst pulsed for 1 cycle at T+5 of a 23-shift operation. Next cycle out_valid=0, in_ready=1, outp=0; a following normal input gives the correct result at its T+2.
